bcd_tick_timer: RTL and testbench
=================================

# bcd_tick_timer

Parametrised BCD timer for the game-control datapath: counts a DIGITS-wide packed-BCD value up or down at a divided tick rate, with pause, preset load, terminal-value detection and a one-cycle timeout strobe. It replaces the fixed 4-digit, count-up-only timer: digit count and tick rate are parameters, and it adds direction, preset/limit, restart, and explicit done/running status. Its `times` bus feeds the seven-segment display driver, and its `time_out`/`done` outputs feed the game FSM.

## Interface
- DIGITS, 4: number of BCD digits; `times`, `preset` and `limit` are 4*DIGITS bits wide.
- CLK_HZ, 100_000_000: input clock frequency.
- TICK_HZ, 1: count rate. DIV = CLK_HZ/TICK_HZ; DIV must be ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that loads `preset`, latches `up` and begins counting; also accepted while running (restart).
- pause  in  1  level; while high, the count and the divider are frozen.
- up  in  1  direction, sampled only on `start`: 1 = count up to `limit`, 0 = count down to 0.
- preset  in  4*DIGITS  packed BCD load value; digit 0 is in bits [3:0].
- limit  in  4*DIGITS  packed BCD terminal value for up mode; ignored in down mode.
- times  out  4*DIGITS  current packed BCD count.
- running  out  1  high in RUN state only.
- done  out  1  high from reaching terminal until the next `start` or reset.
- time_out  out  1  one-cycle strobe on reaching terminal.
- tick  out  1  one-cycle strobe on each counting tick, for display blink logic.

## Operation
- States are IDLE, RUN, PAUSED and DONE.
- Reset (rst=0): state IDLE; all outputs 0; divider 0; direction register 1.
- `start` from any state:
  - Load `times`←preset, with each digit >9 clamped to 9.
  - Latch the direction and clear the divider, `done` and `tick`.
  - Next state is RUN, or PAUSED if `pause`=1 in the same cycle.
  - If the clamped preset already equals the terminal value (0 when counting down, `limit` when counting up), go to DONE instead, with `time_out` pulsed.
- RUN → PAUSED when `pause`=1. PAUSED → RUN when `pause`=0. Divider contents are held across a pause, not cleared.
- In RUN:
  - The divider counts 0..DIV-1. At DIV-1 it wraps to 0, `tick` pulses, and `times` steps by one.
  - Down step: BCD decrement with per-digit borrow (0→9).
  - Up step: BCD increment with per-digit carry (9→0). All-9s wraps to all-0s and counting continues.
- Terminal: when a step produces the terminal value, the state goes to DONE, `time_out`=1 for that cycle, and `done`=1.
- Up mode with preset > limit is allowed: the count wraps through all-0s and stops at `limit`.
- DONE holds `times` at the terminal value. `pause` is ignored in DONE and IDLE.
- `limit` is sampled continuously, not latched on `start`. It must not change during RUN. If it does, compare against the new value; no special handling is required.
- `start` in DONE starts a new run.

## Timing
- `start` at edge N: `times`=preset and `running`=1 are visible after edge N. The first tick occurs at edge N+DIV.
- `tick`, the `times` update, `time_out` and the `done` rise are all registered on the same edge.
- Immediate-terminal `start`: `time_out` and `done` are both high after edge N.
- `pause` is applied on the edge where it is sampled high. If the divider would wrap on that edge, the tick is suppressed; no step is lost, the step simply occurs after resume.
- `start` and `pause` together: the preset loads and the state is PAUSED.
- `start` and reset together: reset wins.
- `time_out` is never high for 2 consecutive cycles, and all outputs are registered.
- Reset is asynchronous assert. Mid-run reset returns all outputs to 0 immediately, with no `time_out`.

## Test plan
Unless stated, the bench uses CLK_HZ=10, TICK_HZ=1 (DIV=10), DIGITS=4.
- Down count: preset=0x0012, up=0, `start` → `times` 0x0012, 0x0011, …, 0x0000 at 10-cycle spacing. `time_out` pulses once as `times` reaches 0x0000 (12 ticks); `done`=1, `running`=0.
- Up with carry: preset=0x0098, limit=0x0101, up=1 → `times` steps 0x0099, 0x0100, then 0x0101 with `time_out`, 30 cycles after load.
- Pause: down from 0x0005 with `pause` held for 37 cycles mid-run → `times` frozen; total elapsed time to terminal is 50+37 cycles; no extra or lost ticks.
- Edge loads:
  - preset=0x0000 in down mode → `done` and `time_out` high after the load edge.
  - preset=0x00F3 → `times` loads 0x0093.
  - `start` and `pause` in the same cycle → state PAUSED with `times`=preset.
- Wrap and restart: DIGITS=2, preset=0x99, limit=0x01, up=1 → 0x00, 0x01 then `time_out`. A restart `start` mid-run reloads and restarts the divider.
- Async reset mid-RUN (off clock edge) → all outputs 0 immediately; state IDLE; no `time_out`.

Source files
------------

// File: rtl/bcd_tick_timer.sv
// Packed-BCD up/down timer with a divided tick, pause, preset load
// and terminal detection for the game-control datapath.
module bcd_tick_timer #(
    parameter int DIGITS  = 4,
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  up,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   times,
    output logic                  running,
    output logic                  done,
    output logic                  time_out,
    output logic                  tick
);

    localparam int W   = 4 * DIGITS;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = $clog2(DIV);
    localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE, S_RUN, S_PAUSED, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    times_q, times_d;
    logic [DW-1:0]   div_q, div_d;
    logic            dir_q, dir_d;
    logic            done_q, done_d;
    logic            time_out_q, time_out_d;
    logic            tick_q, tick_d;
    logic            running_q, running_d;
    logic [W-1:0]    loaded;
    logic [W-1:0]    stepped;

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic is_term(input logic [W-1:0] v, input logic d,
                                     input logic [W-1:0] lim);
        return d ? (v == lim) : (v == '0);
    endfunction

    assign loaded  = bcd_clamp(preset);
    assign stepped = dir_q ? bcd_inc(times_q) : bcd_dec(times_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            times_q    <= '0;
            div_q      <= '0;
            dir_q      <= 1'b1;
            done_q     <= 1'b0;
            time_out_q <= 1'b0;
            tick_q     <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            times_q    <= times_d;
            div_q      <= div_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            time_out_q <= time_out_d;
            tick_q     <= tick_d;
            running_q  <= running_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        times_d    = times_q;
        div_d      = div_q;
        dir_d      = dir_q;
        done_d     = done_q;
        time_out_d = 1'b0;
        tick_d     = 1'b0;
        if (start) begin
            times_d = loaded;
            dir_d   = up;
            div_d   = '0;
            done_d  = 1'b0;
            if (is_term(loaded, up, limit)) begin
                state_d    = S_DONE;
                time_out_d = 1'b1;
                done_d     = 1'b1;
            end else begin
                state_d = pause ? S_PAUSED : S_RUN;
            end
        end else if (state_q == S_RUN || state_q == S_PAUSED) begin
            // a resume edge counts like any run edge, so a pause costs exactly its length
            if (pause) begin
                state_d = S_PAUSED;
            end else begin
                state_d = S_RUN;
                if (div_q == DIV_M1) begin
                    div_d   = '0;
                    tick_d  = 1'b1;
                    times_d = stepped;
                    if (is_term(stepped, dir_q, limit)) begin
                        state_d    = S_DONE;
                        time_out_d = 1'b1;
                        done_d     = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        running_d = (state_d == S_RUN);
    end

    assign times    = times_q;
    assign running  = running_q;
    assign done     = done_q;
    assign time_out = time_out_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_bcd_tick_timer.sv
// Scoreboard bench for bcd_tick_timer: 4-digit and 2-digit instances,
// DIV=10, expected tick values and cycle offsets queued at stimulus time.
module tb_bcd_tick_timer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   t0 = 0;
    int   checks = 0;
    int   failures = 0;

    logic        start4 = 0, pause4 = 0, up4 = 0;
    logic [15:0] preset4 = '0, limit4 = '0, times4;
    logic        running4, done4, to4, tick4;

    logic        start2 = 0, pause2 = 0, up2 = 0;
    logic [7:0]  preset2 = '0, limit2 = '0, times2;
    logic        running2, done2, to2, tick2;

    typedef struct {
        logic [15:0] t;
        int          dt;
        logic        to;
    } exp_t;

    exp_t sb[$];

    bcd_tick_timer #(.DIGITS(4), .CLK_HZ(10), .TICK_HZ(1)) u4 (
        .clk(clk), .rst(rst), .start(start4), .pause(pause4), .up(up4),
        .preset(preset4), .limit(limit4), .times(times4),
        .running(running4), .done(done4), .time_out(to4), .tick(tick4)
    );

    bcd_tick_timer #(.DIGITS(2), .CLK_HZ(10), .TICK_HZ(1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .pause(pause2), .up(up2),
        .preset(preset2), .limit(limit2), .times(times2),
        .running(running2), .done(done2), .time_out(to2), .tick(tick2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input logic [15:0] p, input logic u, input logic pz);
        preset4 = p;
        up4     = u;
        pause4  = pz;
        start4  = 1'b1;
        step();
        start4  = 1'b0;
        t0      = cyc;
    endtask

    task automatic load2(input logic [7:0] p, input logic u);
        preset2 = p;
        up2     = u;
        start2  = 1'b1;
        step();
        start2  = 1'b0;
        t0      = cyc;
    endtask

    task automatic push(input logic [15:0] t, input int dt, input logic to);
        exp_t e;
        e.t  = t;
        e.dt = dt;
        e.to = to;
        sb.push_back(e);
    endtask

    task automatic run_sb(input bit two, input int pa, input int pl);
        int          n;
        int          nx;
        exp_t        e;
        logic [15:0] frz;
        logic [15:0] tv;
        logic        tk, tov;
        n   = 0;
        frz = '0;
        while (sb.size() > 0 && n < 400) begin
            nx = cyc - t0 + 1;
            if (!two) pause4 = (nx >= pa && nx < pa + pl);
            step();
            n++;
            if (!two && pl > 0 && cyc - t0 == pa) frz = times4;
            if (!two && pl > 0 && cyc - t0 == pa + pl - 1) begin
                checks++;
                if (times4 !== frz || running4 !== 1'b0) begin
                    failures++;
                    $display("FAIL pause_freeze times=%h run=%b required %h/0",
                             times4, running4, frz);
                end
            end
            tk = two ? tick2 : tick4;
            if (tk) begin
                e   = sb.pop_front();
                tv  = two ? {8'h00, times2} : times4;
                tov = two ? to2 : to4;
                checks++;
                if (tv !== e.t || (cyc - t0) != e.dt || tov !== e.to) begin
                    failures++;
                    $display("FAIL tick times=%h at=%0d to=%b required %h at=%0d to=%b",
                             tv, cyc - t0, tov, e.t, e.dt, e.to);
                end
            end
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout pending=%0d required 0", sb.size());
            sb.delete();
        end
        pause4 = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({times4, running4, done4, to4, tick4} !== '0 ||
            {times2, running2, done2, to2, tick2} !== '0) begin
            failures++;
            $display("FAIL reset t4=%h t2=%h flags4=%b required 0",
                     times4, times2, {running4, done4, to4, tick4});
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_down();
        limit4 = 16'h0000;
        load4(16'h0012, 1'b0, 1'b0);
        checks++;
        if (times4 !== 16'h0012 || running4 !== 1'b1 || done4 !== 1'b0) begin
            failures++;
            $display("FAIL down_load times=%h run=%b done=%b required 0012/1/0",
                     times4, running4, done4);
        end
        for (int k = 1; k <= 12; k++) push(to_bcd(12 - k), 10 * k, k == 12);
        run_sb(1'b0, 0, 0);
        checks++;
        if (done4 !== 1'b1 || running4 !== 1'b0) begin
            failures++;
            $display("FAIL down_end done=%b run=%b required 1/0", done4, running4);
        end
        step();
        checks++;
        if (to4 !== 1'b0 || times4 !== 16'h0000) begin
            failures++;
            $display("FAIL down_hold to=%b times=%h required 0/0000", to4, times4);
        end
    endtask

    task automatic test_up_carry();
        limit4 = 16'h0101;
        load4(16'h0098, 1'b1, 1'b0);
        push(16'h0099, 10, 1'b0);
        push(16'h0100, 20, 1'b0);
        push(16'h0101, 30, 1'b1);
        run_sb(1'b0, 0, 0);
        checks++;
        if (done4 !== 1'b1) begin
            failures++;
            $display("FAIL up_done done=%b required 1", done4);
        end
    endtask

    task automatic test_pause();
        load4(16'h0005, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++)
            push(to_bcd(5 - k), 10 * k + ((10 * k >= 24) ? 37 : 0), k == 5);
        run_sb(1'b0, 24, 37);
    endtask

    task automatic test_edge_loads();
        load4(16'h0000, 1'b0, 1'b0);
        checks++;
        if (done4 !== 1'b1 || to4 !== 1'b1 || running4 !== 1'b0) begin
            failures++;
            $display("FAIL zero_load done=%b to=%b run=%b required 1/1/0",
                     done4, to4, running4);
        end
        step();
        checks++;
        if (to4 !== 1'b0 || done4 !== 1'b1) begin
            failures++;
            $display("FAIL zero_strobe to=%b done=%b required 0/1", to4, done4);
        end
        load4(16'h00F3, 1'b0, 1'b0);
        checks++;
        if (times4 !== 16'h0093 || running4 !== 1'b1) begin
            failures++;
            $display("FAIL clamp_load times=%h run=%b required 0093/1",
                     times4, running4);
        end
        load4(16'h0042, 1'b0, 1'b1);
        checks++;
        if (times4 !== 16'h0042 || running4 !== 1'b0 || done4 !== 1'b0) begin
            failures++;
            $display("FAIL start_pause times=%h run=%b done=%b required 0042/0/0",
                     times4, running4, done4);
        end
        repeat (15) step();
        checks++;
        if (times4 !== 16'h0042 || tick4 !== 1'b0 || running4 !== 1'b0) begin
            failures++;
            $display("FAIL paused_hold times=%h tick=%b run=%b required 0042/0/0",
                     times4, tick4, running4);
        end
        pause4 = 1'b0;
    endtask

    task automatic test_wrap_restart();
        limit2 = 8'h01;
        load2(8'h99, 1'b1);
        push(16'h0000, 10, 1'b0);
        push(16'h0001, 20, 1'b1);
        run_sb(1'b1, 0, 0);
        load2(8'h99, 1'b1);
        repeat (15) step();
        load2(8'h50, 1'b0);
        checks++;
        if (times2 !== 8'h50 || running2 !== 1'b1 || done2 !== 1'b0) begin
            failures++;
            $display("FAIL restart_load times=%h run=%b done=%b required 50/1/0",
                     times2, running2, done2);
        end
        push(16'h0049, 10, 1'b0);
        run_sb(1'b1, 0, 0);
    endtask

    task automatic test_async_reset();
        load4(16'h0012, 1'b0, 1'b0);
        repeat (15) step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({times4, running4, done4, to4, tick4} !== '0) begin
            failures++;
            $display("FAIL async_reset times=%h flags=%b required 0",
                     times4, {running4, done4, to4, tick4});
        end
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        checks++;
        if (times4 !== 16'h0000 || to4 !== 1'b0 || running4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_wins times=%h to=%b run=%b required 0000/0/0",
                     times4, to4, running4);
        end
        rst = 1'b1;
        repeat (12) step();
        checks++;
        if (times4 !== 16'h0000 || running4 !== 1'b0 || tick4 !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle times=%h run=%b tick=%b required 0000/0/0",
                     times4, running4, tick4);
        end
    endtask

    initial begin
        test_reset();
        test_down();
        test_up_carry();
        test_pause();
        test_edge_loads();
        test_wrap_restart();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
